bf2_sdf_stage: RTL
==================

BF2_SDF_STAGE -- requirements
Module: bf2_sdf_stage

Interface
REQ-001 Parameter: DEPTH, default 4, delay-line length (N/2 of an 8-point stage); SHALL be a power of two, minimum 2.
REQ-002 Parameter: IW, default 13, input sample width; output width SHALL be IW+1.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 din_R, din_Q  in  IW each  signed input sample (real, imaginary).
REQ-006 din_valid  in  1  input sample offered.
REQ-007 din_ready  out  1  stage accepts input; a transfer SHALL occur when din_valid and din_ready are both 1.
REQ-008 flush  in  1  request to drain pending differences without new input.
REQ-009 dout_R, dout_Q  out  IW+1 each  signed butterfly result, feeding the twiddle-multiply stage.
REQ-010 dout_valid  out  1  single-cycle qualifier; no backpressure from downstream.
REQ-011 tw_idx  out  log2(2*DEPTH)  twiddle exponent k of W(2*DEPTH)^k for the downstream multiplier; with DEPTH=4, k=3 selects -0.707-j0.707.
REQ-012 dout_sop  out  1  marks the first sum output of each frame.

Function
REQ-013 Counter cnt, modulo 2*DEPTH, SHALL advance only on an accepted input.
REQ-014 State FILL (cnt < DEPTH), accepted x: x SHALL be pushed into the delay line; if pending=1, the popped head (a stored difference) SHALL be output with tw_idx=cnt.
REQ-015 State COMBINE (cnt >= DEPTH), accepted b with head a: a+b SHALL be output with tw_idx=0, and a-b SHALL be pushed.
REQ-016 Transitions: FILL->COMBINE when cnt reaches DEPTH; COMBINE->FILL on wrap to 0, setting pending=1.
REQ-017 pending SHALL clear after the last of DEPTH differences is emitted, unless COMBINE has just refilled it.
REQ-018 FLUSH SHALL be entered from FILL only when cnt=0, pending=1 and flush=1.
REQ-019 In FLUSH, the stage SHALL emit one stored difference per cycle for DEPTH cycles with tw_idx=0..DEPTH-1, then clear pending and return to FILL.
REQ-020 din_ready SHALL be 0 in FLUSH and 1 otherwise.
REQ-021 flush with pending=0, or with cnt != 0, SHALL be ignored.
REQ-022 Outputs SHALL be registered: latency of exactly 1 clk from the accepting edge (or the FLUSH cycle) to dout_valid.
REQ-023 Sum and difference SHALL be computed at full IW+1 width with no rounding, shifting or saturation.
REQ-024 dout_sop SHALL be 1 with the output produced at cnt=DEPTH.
REQ-025 din_valid gaps SHALL freeze cnt, state and delay line; dout_valid SHALL be 0 in cycles with no transfer and no FLUSH emission.
REQ-026 Frame order: dout_valid, dout_R, dout_Q, tw_idx and dout_sop SHALL change only with a registered update.

Reset
REQ-027 rst=1 SHALL set:
- dout_R/dout_Q = 0, dout_valid = 0, tw_idx = 0, dout_sop = 0
- cnt = 0, pending = 0, state = FILL, delay line cleared to 0
- din_ready = 1 on the first cycle after rst deasserts
REQ-028 rst asserted mid-frame or mid-FLUSH SHALL discard all stored samples; no stale output SHALL appear afterwards.

Structure
REQ-029 Shared package fft_pkg SHALL hold the state enum (FILL, COMBINE, FLUSH), the default DEPTH/IW constants, and the tw_idx width function.
REQ-030 Delay line SHALL be a separate sub-module sdf_delay_line: push/pop shift register, DEPTH x 2*(IW+1) bits, shift enable only.

Verification
REQ-031 Frame din_R=1..8, din_Q=0, continuous valid -> sums 6,8,10,12 (tw_idx 0, sop on the 6), then flush -> -4,-4,-4,-4 with tw_idx 0,1,2,3.
REQ-032 Two back-to-back frames, second all zero -> first frame's differences interleave into the second frame's FILL outputs with no flush needed; din_ready stays 1.
REQ-033 Extremes din=-4096 in both halves -> sum -8192; din=4095 then -4096 -> difference 8191; no wrap.
REQ-034 din_valid toggling 1-0-1 across a frame -> identical output values and tw_idx sequence to the continuous case; dout_valid only on transfer cycles +1.
REQ-035 rst pulsed at cnt=6 -> all outputs 0 next cycle; a subsequent flush is ignored (pending=0).
REQ-036 flush asserted at cnt=2 -> ignored; din_ready remains 1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 single-delay-feedback FFT stages:
// stage states, default geometry and the twiddle-index width helper.
package fft_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        COMBINE = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_IW    = 13;

    // Twiddle exponent k of W(2*DEPTH)^k spans 0 .. 2*DEPTH-1.
    function automatic int tw_width(input int depth);
        return $clog2(2 * depth);
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Push/pop shift register: head_o is the oldest entry; one shift pops it and
// appends push_i at the tail.
module sdf_delay_line
    import fft_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = 2 * (DEF_IW + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en_i,
    input  logic [W-1:0] push_i,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_q[i] <= mem_q[i + 1];
            end
            mem_q[DEPTH - 1] <= push_i;
        end
    end

    assign head_o = mem_q[0];

endmodule

// File: rtl/bf2_sdf_stage.sv
// Radix-2 SDF butterfly stage: first half of a frame fills the delay line,
// second half emits sums and stores differences that drain during the next FILL or a FLUSH.
module bf2_sdf_stage
    import fft_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = DEF_IW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [IW-1:0]       din_R,
    input  logic signed [IW-1:0]       din_Q,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic                       flush,
    output logic signed [IW:0]         dout_R,
    output logic signed [IW:0]         dout_Q,
    output logic                       dout_valid,
    output logic [tw_width(DEPTH)-1:0] tw_idx,
    output logic                       dout_sop
);

    localparam int OW = IW + 1;
    localparam int CW = tw_width(DEPTH);

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        fcnt_q;
    logic                 pending_q;
    logic signed [OW-1:0] dout_r_q, dout_q_q;
    logic                 dout_valid_q, dout_sop_q;
    logic [CW-1:0]        tw_idx_q;

    logic signed [OW-1:0] in_r, in_q, head_r, head_q;
    logic signed [OW-1:0] sum_r, sum_q, diff_r, diff_q;
    logic [2*OW-1:0]      head_w, push_w;
    logic                 accept, shift_en;

    assign din_ready = (state_q != FLUSH);
    assign accept    = din_valid && din_ready;
    assign shift_en  = accept || (state_q == FLUSH);

    assign in_r   = OW'(din_R);
    assign in_q   = OW'(din_Q);
    assign head_r = head_w[2*OW-1:OW];
    assign head_q = head_w[OW-1:0];
    assign sum_r  = head_r + in_r;
    assign sum_q  = head_q + in_q;
    assign diff_r = head_r - in_r;
    assign diff_q = head_q - in_q;

    always_comb begin
        push_w = {in_r, in_q};
        if (state_q == COMBINE) begin
            push_w = {diff_r, diff_q};
        end else if (state_q == FLUSH) begin
            push_w = '0;
        end
    end

    sdf_delay_line #(
        .DEPTH(DEPTH),
        .W    (2 * OW)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .shift_en_i(shift_en),
        .push_i    (push_w),
        .head_o    (head_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            fcnt_q       <= '0;
            pending_q    <= 1'b0;
            dout_r_q     <= '0;
            dout_q_q     <= '0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            tw_idx_q     <= '0;
        end else begin
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (pending_q) begin
                            dout_r_q     <= head_r;
                            dout_q_q     <= head_q;
                            dout_valid_q <= 1'b1;
                            tw_idx_q     <= cnt_q;
                        end
                        if (cnt_q == CW'(DEPTH - 1)) begin
                            pending_q <= 1'b0;
                            state_q   <= COMBINE;
                        end
                        cnt_q <= cnt_q + CW'(1);
                    // An accepted sample already drains a difference, so it takes priority over flush.
                    end else if (flush && pending_q && cnt_q == '0) begin
                        state_q <= FLUSH;
                        fcnt_q  <= '0;
                    end
                end
                COMBINE: begin
                    if (accept) begin
                        dout_r_q     <= sum_r;
                        dout_q_q     <= sum_q;
                        dout_valid_q <= 1'b1;
                        tw_idx_q     <= '0;
                        dout_sop_q   <= (cnt_q == CW'(DEPTH));
                        if (cnt_q == CW'(2 * DEPTH - 1)) begin
                            pending_q <= 1'b1;
                            state_q   <= FILL;
                        end
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FLUSH: begin
                    dout_r_q     <= head_r;
                    dout_q_q     <= head_q;
                    dout_valid_q <= 1'b1;
                    tw_idx_q     <= fcnt_q;
                    fcnt_q       <= fcnt_q + CW'(1);
                    if (fcnt_q == CW'(DEPTH - 1)) begin
                        pending_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign dout_R     = dout_r_q;
    assign dout_Q     = dout_q_q;
    assign dout_valid = dout_valid_q;
    assign dout_sop   = dout_sop_q;
    assign tw_idx     = tw_idx_q;

endmodule
